// File: rtl/clock_gate_ctrl.sv
// Per-unit clock-gating controller: wakes ALU sub-units on request, flags ready after a fixed wake
// latency, and gates them off after an idle period. Optional macro CLOCK_GATE_CTRL_STATS_EN adds active_cycles.
//
// state   | meaning
// ST_OFF  | unit clock gated, gate_en=0, ready=0
// ST_WAKE | gate_en=1, waiting WAKE_CYCLES for the unit clock to settle
// ST_ON   | gate_en=1, ready=1, idle counter running while req|busy low
module clock_gate_ctrl #(
  parameter int unsigned NUM_UNITS   = 4,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned IDLE_CYCLES = 8,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_UNITS-1:0] req,
  input  logic [NUM_UNITS-1:0] busy,
  input  logic                 sleep_all,
  output logic [NUM_UNITS-1:0] gate_en,
`ifdef CLOCK_GATE_CTRL_STATS_EN
  output logic [31:0]          active_cycles,
`endif
  output logic [NUM_UNITS-1:0] ready
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             g_en;
    logic             rdy;

    always_ff @(posedge clk) begin
      if (rst) begin
        state <= ST_OFF;
        cnt   <= '0;
        g_en  <= 1'b0;
        rdy   <= 1'b0;
      end else begin
        case (state)
          ST_OFF: begin
            if (req[u]) begin
              state <= ST_WAKE;
              cnt   <= '0;
              g_en  <= 1'b1;
            end
          end
          ST_WAKE: begin
            if (cnt == WAKE_LAST) begin
              state <= ST_ON;
              cnt   <= '0;
              rdy   <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_ON: begin
            // activity beats both the idle timeout and sleep_all
            if (req[u] || busy[u]) begin
              cnt <= '0;
            end else if (sleep_all || (cnt == IDLE_LAST)) begin
              state <= ST_OFF;
              cnt   <= '0;
              g_en  <= 1'b0;
              rdy   <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= ST_OFF;
            cnt   <= '0;
            g_en  <= 1'b0;
            rdy   <= 1'b0;
          end
        endcase
      end
    end

    assign gate_en[u] = g_en;
    assign ready[u]   = rdy;
  end

`ifdef CLOCK_GATE_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      active_cycles <= '0;
    end else if ((|gate_en) && (active_cycles != 32'hFFFF_FFFF)) begin
      active_cycles <= active_cycles + 32'd1;
    end
  end
`endif

endmodule
